// File: rtl/mac_st_feeder.sv
// ---------------------------------------------------------------------------
// mac_st_feeder
//
// Operand packer and result collector for the 2-level Sum-Together MAC
// (8/4/2-bit). Elements arrive one per cycle on a valid/ready stream. They are
// packed into 1, 2 or 4 lanes of the 8-bit a/w words that the MAC consumes.
// The first word of every dot product carries accu_rst. After the last element
// the block waits out the MAC latency. It then captures z into a one-entry
// result register with a valid/ready handshake.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     element stream handshake
//   in_a, in_w, in_last   activation (unsigned), weight, last-of-dot-product
//   cfg_aw                precision select: 00 = 8b, 01 = 4b, 11 = 2b (10 illegal)
//   mac_a, mac_w          packed operand words to the MAC
//   mac_config_aw         latched precision to the MAC
//   mac_accu_rst          accumulator restart, high with the first word
//   mac_z                 MAC accumulator output
//   res_z, res_valid,
//   res_ready             captured result and its handshake
//   cfg_err               sticky: an illegal cfg_aw started a dot product
// ---------------------------------------------------------------------------
module mac_st_feeder #(
    parameter int HEADROOM = 4,
    parameter int MAC_LAT  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_a,
    input  logic [7:0]              in_w,
    input  logic                    in_last,
    input  logic [1:0]              cfg_aw,
    output logic [7:0]              mac_a,
    output logic [7:0]              mac_w,
    output logic [1:0]              mac_config_aw,
    output logic                    mac_accu_rst,
    input  logic [16+HEADROOM-1:0]  mac_z,
    output logic [16+HEADROOM-1:0]  res_z,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    cfg_err
);

    localparam int          ZW      = 16 + HEADROOM;
    localparam logic [2:0]  LAT_CNT = 3'(MAC_LAT);

    typedef enum logic {S_OPEN, S_HOLD} state_t;

    state_t          state_reg;
    logic [2:0]      cnt_reg;
    logic [1:0]      lane_reg;
    logic [7:0]      pack_a_reg;
    logic [7:0]      pack_w_reg;
    logic [1:0]      cfg_reg;
    logic            cfg_err_reg;
    logic            dp_open_reg;
    logic            first_reg;      // next issued word is the first of its dot product
    logic [7:0]      mac_a_reg;
    logic [7:0]      mac_w_reg;
    logic            accu_rst_reg;
    logic [ZW-1:0]   res_z_reg;
    logic            res_valid_reg;

    logic            accept;
    logic [1:0]      cfg_legal;
    logic [1:0]      cfg_eff;
    logic [1:0]      lane_max;
    logic [2:0]      lane_shift;
    logic [7:0]      elem_mask;
    logic [7:0]      word_a;
    logic [7:0]      word_w;
    logic            issue;
    logic            capture;

    assign in_ready = !rst && (state_reg == S_OPEN);
    assign accept   = in_valid && in_ready;

    // An illegal 10 runs as 8-bit; cfg_err records that it happened.
    assign cfg_legal = (cfg_aw == 2'b10) ? 2'b00 : cfg_aw;
    // The first element of a dot product already uses the incoming config.
    // Later elements use the latched config and ignore cfg_aw changes.
    assign cfg_eff   = dp_open_reg ? cfg_reg : cfg_legal;

    always_comb begin
        lane_max   = 2'd0;
        lane_shift = 3'd0;
        elem_mask  = 8'hFF;
        case (cfg_eff)
            2'b01: begin
                lane_max   = 2'd1;
                lane_shift = {lane_reg[0], 2'b00};
                elem_mask  = 8'h0F;
            end
            2'b11: begin
                lane_max   = 2'd3;
                lane_shift = {lane_reg, 1'b0};
                elem_mask  = 8'h03;
            end
            default: begin
                lane_max   = 2'd0;
                lane_shift = 3'd0;
                elem_mask  = 8'hFF;
            end
        endcase
    end

    // Merge the incoming element into its lane. Lanes not yet filled stay zero,
    // so a word padded by in_last adds nothing for those lanes.
    assign word_a = pack_a_reg | ((in_a & elem_mask) << lane_shift);
    assign word_w = pack_w_reg | ((in_w & elem_mask) << lane_shift);
    assign issue  = accept && ((lane_reg == lane_max) || in_last);

    assign capture = (state_reg == S_HOLD) && (cnt_reg == 3'd0) &&
                     (!res_valid_reg || res_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_OPEN;
            cnt_reg       <= 3'd0;
            lane_reg      <= 2'd0;
            pack_a_reg    <= 8'h00;
            pack_w_reg    <= 8'h00;
            cfg_reg       <= 2'b00;
            cfg_err_reg   <= 1'b0;
            dp_open_reg   <= 1'b0;
            first_reg     <= 1'b1;
            mac_a_reg     <= 8'h00;
            mac_w_reg     <= 8'h00;
            accu_rst_reg  <= 1'b0;
            res_z_reg     <= '0;
            res_valid_reg <= 1'b0;
        end else begin
            // Bubble by default: zero operands keep the accumulator unchanged.
            mac_a_reg    <= 8'h00;
            mac_w_reg    <= 8'h00;
            accu_rst_reg <= 1'b0;

            if (accept) begin
                if (!dp_open_reg) begin
                    cfg_reg <= cfg_legal;
                    if (cfg_aw == 2'b10) begin
                        cfg_err_reg <= 1'b1;
                    end
                end
                if (issue) begin
                    mac_a_reg    <= word_a;
                    mac_w_reg    <= word_w;
                    accu_rst_reg <= first_reg;
                    first_reg    <= 1'b0;
                    pack_a_reg   <= 8'h00;
                    pack_w_reg   <= 8'h00;
                    lane_reg     <= 2'd0;
                end else begin
                    pack_a_reg <= word_a;
                    pack_w_reg <= word_w;
                    lane_reg   <= lane_reg + 2'd1;
                end
                if (in_last) begin
                    dp_open_reg <= 1'b0;
                    first_reg   <= 1'b1;
                    state_reg   <= S_HOLD;
                    cnt_reg     <= LAT_CNT;
                end else begin
                    dp_open_reg <= 1'b1;
                end
            end

            // Count down the MAC latency, then wait for room in the result register.
            if ((state_reg == S_HOLD) && (cnt_reg != 3'd0)) begin
                cnt_reg <= cnt_reg - 3'd1;
            end

            if (capture) begin
                res_z_reg     <= mac_z;
                res_valid_reg <= 1'b1;
                state_reg     <= S_OPEN;
            end else if (res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign mac_a         = mac_a_reg;
    assign mac_w         = mac_w_reg;
    assign mac_config_aw = cfg_reg;
    assign mac_accu_rst  = accu_rst_reg;
    assign res_z         = res_z_reg;
    assign res_valid     = res_valid_reg;
    assign cfg_err       = cfg_err_reg;

endmodule
